// File: rtl/calc_multicycle_core.sv
// Multicycle calculator core: FETCH/DECODE/EXEC/MEM/WB sequencing over one
// shared req/ack memory port, with a sticky halt and a retired-instruction count.
module calc_multicycle_core #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 2,
   parameter int IMM_W  = 25,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              _clock,
   input  logic              _reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   localparam int          INSN_W = 3 + 2*REG_AW + IMM_W;
   localparam int unsigned NREGS  = 2**REG_AW;
   localparam int          AW_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [2:0] OP_ADDI  = 3'd0;
   localparam logic [2:0] OP_SUBI  = 3'd1;
   localparam logic [2:0] OP_MULI  = 3'd2;
   localparam logic [2:0] OP_LOAD  = 3'd3;
   localparam logic [2:0] OP_STORE = 3'd4;
   localparam logic [2:0] OP_HCT   = 3'd5;
   localparam logic [2:0] OP_LI    = 3'd6;
   localparam logic [2:0] OP_ADDR  = 3'd7;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INSN_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] s_q, s_d, d_q, d_d, res_q, res_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              halted_q, halted_d;
   logic              req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic              wr_en;

   logic [2:0]        op;
   logic [REG_AW-1:0] src, dst;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] ximm, ea_sum;
   logic [AW_MAX-1:0] ea_ext;
   logic              xfer;

   assign op     = ir_q[INSN_W-1 -: 3];
   assign src    = ir_q[INSN_W-4 -: REG_AW];
   assign dst    = ir_q[IMM_W +: REG_AW];
   assign imm    = ir_q[IMM_W-1:0];
   assign ximm   = DATA_W'($signed(imm));
   assign ea_sum = s_q + ximm;
   assign ea_ext = AW_MAX'(ea_sum);
   assign xfer   = req_q & mem_ack;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      s_d       = s_q;
      d_d       = d_q;
      res_d     = res_q;
      retired_d = retired_q;
      halted_d  = halted_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_en     = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (xfer) begin
               ir_d    = mem_rdata[INSN_W-1:0];
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            s_d = regs_q[src];
            d_d = regs_q[dst];
            if (op == OP_HCT) begin
               state_d   = S_HALT;
               halted_d  = 1'b1;
               retired_d = retired_q + CNT_W'(1);
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
            case (op)
               OP_ADDI: res_d = s_q + ximm;
               OP_SUBI: res_d = s_q - ximm;
               OP_MULI: res_d = s_q * ximm;
               OP_LI:   res_d = ximm;
               OP_ADDR: res_d = d_q + s_q;
               OP_LOAD, OP_STORE: begin
                  state_d = S_MEM;
                  addr_d  = ea_ext[ADDR_W-1:0];
                  wdata_d = d_q;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (xfer) begin
               if (op == OP_STORE) begin
                  retired_d = retired_q + CNT_W'(1);
                  state_d   = S_FETCH;
               end else begin
                  res_d   = mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            wr_en     = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
      // Request is a function of the next state, so it is already high in the
      // first FETCH/MEM cycle and drops right after the completing ack edge.
      req_d = (state_d == S_FETCH) || (state_d == S_MEM);
      we_d  = (state_d == S_MEM) && (op == OP_STORE);
      if (state_d == S_FETCH) addr_d = pc_d;
   end

   always_ff @(posedge _clock or posedge _reset) begin
      if (_reset) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         s_q       <= '0;
         d_q       <= '0;
         res_q     <= '0;
         retired_q <= '0;
         halted_q  <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         s_q       <= s_d;
         d_q       <= d_d;
         res_q     <= res_d;
         retired_q <= retired_d;
         halted_q  <= halted_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         if (wr_en) regs_q[dst] <= res_q;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign pc        = pc_q;
   assign halted    = halted_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_calc_multicycle_core.sv
// Scoreboarded bench for calc_multicycle_core: directed programs against a
// wait-state memory model, plus a narrow-datapath parameter instance.
module tb_calc_multicycle_core;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_ack, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;

   logic        rst16 = 1'b1;
   logic        req16, we16, ack16, halted16;
   logic [31:0] addr16, pc16, retired16;
   logic [15:0] wdata16, rdata16;

   logic [31:0] mem   [256];
   logic [15:0] mem16 [16];
   int unsigned wait_cycles = 0;
   int unsigned wcnt = 0;
   logic        force_ack = 1'b0;
   logic        stall_en = 1'b0;
   logic [31:0] stall_addr = '0;

   xfer_t exp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   calc_multicycle_core #(.DATA_W(32), .REG_AW(2), .IMM_W(25), .ADDR_W(32), .CNT_W(32)) dut (
      ._clock(clk), ._reset(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pc(pc), .halted(halted), .retired(retired));

   calc_multicycle_core #(.DATA_W(16), .REG_AW(3), .IMM_W(7), .ADDR_W(32), .CNT_W(32)) dut16 (
      ._clock(clk), ._reset(rst16),
      .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
      .mem_rdata(rdata16), .mem_ack(ack16),
      .pc(pc16), .halted(halted16), .retired(retired16));

   // Memory: ack after wait_cycles of request, optionally stalled on one address.
   assign mem_ack   = force_ack ||
                      (mem_req && (wcnt >= wait_cycles) && !(stall_en && mem_addr == stall_addr));
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (!mem_req || mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   assign ack16   = req16;
   assign rdata16 = mem16[addr16[3:0]];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every completed transfer is popped against the scoreboard.
   logic        prev_wait = 1'b0;
   logic [95:0] prev_sig = '0;
   always @(negedge clk) begin : monitor
      xfer_t       e;
      logic [95:0] sig;
      sig = {31'b0, mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
      if (mem_req) begin
         if (prev_wait) check("hold_stable", sig, prev_sig);
         if (mem_ack) begin
            check("xfer_expected", 96'(exp_q.size() > 0), 96'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("xfer", sig, {31'b0, e.we, e.addr, (e.we ? e.data : 32'h0)});
            end
         end
      end
      prev_sig  = sig;
      prev_wait = mem_req && !mem_ack;
   end

   function automatic logic [31:0] enc(input int op, input int src, input int dst, input int imm);
      logic [31:0] o = op, s = src, d = dst, m = imm;
      return {o[2:0], s[1:0], d[1:0], m[24:0]};
   endfunction

   function automatic logic [15:0] enc16(input int op, input int src, input int dst, input int imm);
      logic [31:0] o = op, s = src, d = dst, m = imm;
      return {o[2:0], s[2:0], d[2:0], m[6:0]};
   endfunction

   task automatic push_f(input int a);
      exp_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
   endtask

   task automatic push_w(input int a, input logic [31:0] d);
      exp_q.push_back('{we: 1'b1, addr: a, data: d});
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      force_ack = 1'b0;
      stall_en = 1'b0;
      wait_cycles = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("reset_pc", pc, 0);
      check("reset_req", mem_req, 0);
      check("reset_we", mem_we, 0);
      check("reset_addr", mem_addr, 0);
      check("reset_wdata", mem_wdata, 0);
      check("reset_retired", retired, 0);
      check("reset_halted", halted, 0);
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic run_to_halt(input int budget);
      for (int k = 0; k < budget && !halted; k++) @(negedge clk);
      check("halt_reached", halted, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp16 [8];

      // Zero-wait: one edge arms the fetch request, then 4+4+4+2 edges to HALT.
      reset_dut();
      mem[0] = enc(6, 0, 1, 5);
      mem[1] = enc(0, 1, 2, -3);
      mem[2] = enc(7, 1, 2, 0);
      mem[3] = enc(5, 0, 0, 0);
      for (int i = 0; i < 4; i++) push_f(i);
      @(negedge clk) rst = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) check("first_fetch_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0});
         if (k == 14) check("halted_before_edge15", halted, 0);
         if (k == 15) check("halted_at_edge15", halted, 1);
      end
      check("t1_pc", pc, 4);
      check("t1_retired", retired, 4);
      check("t1_r1", dut.regs_q[1], 5);
      check("t1_r2", dut.regs_q[2], 7);

      // Ack held high while halted must not start any transfer.
      force_ack = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("halt_no_req", mem_req, 0);
      end
      force_ack = 1'b0;
      check("halt_pc_frozen", pc, 4);
      check("halt_retired_frozen", retired, 4);
      check("halt_sticky", halted, 1);
      check("t1_drained", exp_q.size(), 0);

      // Three wait states on every transfer; store then reload the same word.
      reset_dut();
      wait_cycles = 3;
      mem[0] = enc(6, 0, 1, 100);
      mem[1] = enc(6, 0, 3, 'hABC);
      mem[2] = enc(4, 1, 3, 4);
      mem[3] = enc(3, 1, 2, 4);
      mem[4] = enc(4, 0, 2, 200);
      mem[5] = enc(5, 0, 0, 0);
      push_f(0); push_f(1); push_f(2); push_w(104, 32'hABC);
      push_f(3); push_f(104); push_f(4); push_w(200, 32'hABC); push_f(5);
      @(negedge clk) rst = 1'b0;
      run_to_halt(300);
      check("t2_mem104", mem[104], 32'hABC);
      check("t2_mem200_r2", mem[200], 32'hABC);
      check("t2_retired", retired, 6);
      check("t2_pc", pc, 6);
      check("t2_drained", exp_q.size(), 0);

      // Wraparound: ADDI -1+1, MULI 2^16*2^16, SUBI 0-1.
      reset_dut();
      mem[0] = enc(6, 0, 1, -1);
      mem[1] = enc(0, 1, 1, 1);
      mem[2] = enc(6, 0, 2, 'h10000);
      mem[3] = enc(2, 2, 2, 'h10000);
      mem[4] = enc(4, 0, 1, 60);
      mem[5] = enc(4, 0, 2, 61);
      mem[6] = enc(1, 1, 3, 1);
      mem[7] = enc(4, 0, 3, 62);
      mem[8] = enc(5, 0, 0, 0);
      for (int i = 0; i < 5; i++) push_f(i);
      push_w(60, 32'h0); push_f(5); push_w(61, 32'h0); push_f(6); push_f(7);
      push_w(62, 32'hFFFF_FFFF); push_f(8);
      @(negedge clk) rst = 1'b0;
      run_to_halt(200);
      check("t3_retired", retired, 9);
      check("t3_pc", pc, 9);
      check("t3_drained", exp_q.size(), 0);

      // Reset while the second fetch is stalled, then refetch from 0.
      reset_dut();
      mem[0] = enc(6, 0, 1, 9);
      mem[1] = enc(5, 0, 0, 0);
      stall_en = 1'b1;
      stall_addr = 32'd1;
      push_f(0);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 50 && retired != 1; k++) @(negedge clk);
      check("t5_li_retired", retired, 1);
      repeat (3) @(negedge clk);
      check("t5_stalled_req", {mem_req, mem_addr}, {1'b1, 32'd1});
      check("t5_r1_before", dut.regs_q[1], 9);
      #2 rst = 1'b1;
      #1;
      check("t5_reset_drops_req", mem_req, 0);
      check("t5_reset_pc", pc, 0);
      check("t5_reset_r1", dut.regs_q[1], 0);
      check("t5_reset_retired", retired, 0);
      @(negedge clk);
      stall_en = 1'b0;
      push_f(0); push_f(1);
      rst = 1'b0;
      run_to_halt(50);
      check("t5_retired", retired, 2);
      check("t5_pc", pc, 2);
      check("t5_r1_after", dut.regs_q[1], 9);
      check("t5_drained", exp_q.size(), 0);

      // Narrow instance: 16-bit data, 8 registers, 7-bit immediate.
      for (int i = 0; i < 16; i++) mem16[i] = '0;
      for (int i = 0; i < 6; i++) begin
         mem16[i] = enc16(6, 0, i, 10 + i);
         exp16[i] = 16'(10 + i);
      end
      mem16[6] = enc16(6, 0, 7, -64);
      mem16[7] = enc16(1, 7, 6, 1);
      mem16[8] = enc16(5, 0, 0, 0);
      exp16[6] = 16'hFFBF;
      exp16[7] = 16'hFFC0;
      @(negedge clk) rst16 = 1'b0;
      for (int k = 0; k < 100 && !halted16; k++) @(negedge clk);
      check("sweep_halted", halted16, 1);
      check("sweep_retired", retired16, 9);
      check("sweep_pc", pc16, 9);
      check("sweep_no_store_data", wdata16, 0);
      for (int i = 0; i < 8; i++) check($sformatf("sweep_r%0d", i), dut16.regs_q[i], exp16[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_multicycle_core.md
# calc_multicycle_core

Parametrised multicycle successor to the calculator datapath: one FSM sequences fetch, decode, execute, memory and write-back over a single shared memory port with a req/ack handshake. It replaces the free-running PC and always-on ALU/register path with explicit states, wait-state tolerance, an async reset and a sticky HCT halt. It sits between the unified instruction/data memory and the testbench/top level.

## Interface
- DATA_W, 32: register, ALU and memory data width.
- REG_AW, 2: register address width; 2**REG_AW registers.
- IMM_W, 25: immediate width, sign-extended to DATA_W.
- ADDR_W, 32: memory address and PC width.
- CNT_W, 32: retired-instruction counter width.
- Instruction width INSN_W = 3 + 2*REG_AW + IMM_W (32 at defaults); fields MSB to LSB: opcode[3], src[REG_AW], dest[REG_AW], imm[IMM_W].
- Instructions occupy the low INSN_W bits of mem_rdata; INSN_W <= DATA_W is required.
- _clock  in  1  sole clock; all state updates on the rising edge.
- _reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  transfer request, held until ack.
- mem_we  out  1  1 = write (STORE), 0 = read (fetch, LOAD).
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data; valid while mem_ack = 1.
- mem_ack  in  1  transfer completes at the edge where mem_req = mem_ack = 1.
- pc  out  ADDR_W  address of the next fetch.
- halted  out  1  HCT executed; sticky.
- retired  out  CNT_W  count of completed instructions, HCT included.

## Operation
- Opcodes, with S = reg[src], D = reg[dest], X = sext(imm):
  - 000 ADDI: D <= S + X.
  - 001 SUBI: D <= S - X.
  - 010 MULI: D <= low DATA_W bits of S*X.
  - 011 LOAD: D <= mem[S+X].
  - 100 STORE: mem[S+X] <= D.
  - 101 HCT: halt.
  - 110 LI: D <= X.
  - 111 ADDR: D <= D + S.
- Arithmetic wraps modulo 2**DATA_W. The memory address is the low ADDR_W bits of S+X. No flags, no traps.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack, latch the instruction and pc <= pc+1 (wraps at 2**ADDR_W); go to DECODE.
  - DECODE: latch S and D from the register bank. HCT goes to HALT; all others go to EXEC.
  - EXEC: compute the ALU result or the address. LOAD/STORE go to MEM; all others go to WB.
  - MEM: mem_req=1, mem_we=1 for STORE. On ack, LOAD goes to WB with mem_rdata latched; STORE goes to FETCH.
  - WB: write the result to dest; go to FETCH.
  - HALT: absorbing state until reset; mem_req=0.
- retired increments on the edge leaving WB, on STORE's ack edge, and on the DECODE→HALT edge. It wraps at 2**CNT_W.
- Outside FETCH/MEM, mem_req=0 and mem_we=0. mem_addr/mem_wdata are don't-care when mem_req=0.
- Register writes occur only in WB. A register written in WB is read correctly by the next instruction's DECODE.
- Reset values (asserted asynchronously):
  - state = FETCH, pc = 0, all registers = 0.
  - retired = 0, halted = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Reset mid-transfer drops mem_req immediately. Memory must abandon the transfer; no partial register write occurs.

## Timing
- With zero-wait memory (ack in the same cycle as req):
  - ALU/LI/ADDR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - HCT: 2 cycles to HALT.
- Each cycle with mem_req=1 and mem_ack=0 adds one cycle. Address, we and wdata are held stable through the wait.
- mem_req is registered and asserted in the first FETCH/MEM cycle. It deasserts in the cycle after the ack edge.
- mem_ack while mem_req=0 is ignored.
- First fetch of address 0 is issued in the first cycle after reset release.
- halted rises on the edge entering HALT. pc then holds the address following the HCT.

## Test plan
- Program `LI r1,5; ADDI r2,r1,-3; ADDR r2,r1; HCT`, zero-wait → r2=7, retired=4, halted=1 at cycle 14, pc=4.
- `LI r1,100; LI r3,0xABC; STORE r3,[r1+4]; LOAD r2,[r1+4]; HCT`, ack delayed 3 cycles on every transfer → memory[104]=0xABC, r2=0xABC, each transfer holds mem_addr/mem_we stable while waiting.
- MULI/ADDI wrap: `LI r1,-1; ADDI r1,r1,1; LI r2,0x10000; MULI r2,r2,0x10000` → r1=0, r2=0 (DATA_W=32).
- After HCT, keep ack high for 20 cycles → mem_req stays 0, pc and retired are frozen, halted stays 1.
- Assert _reset mid-FETCH while ack is withheld → mem_req falls the same cycle, pc=0, registers cleared. Release → refetch from 0.
- Parameter sweep DATA_W=16, REG_AW=3, IMM_W=7 (INSN_W=16): `LI r7,-64; SUBI r6,r7,1` → r6=0xFFBF, all 8 registers addressable.
